gpu_command_decoder: RTL
========================

# gpu_command_decoder

Consumes the one-per-cycle command/data pair stream the GPU command buffer delivers on the GPU side and executes it: writes and reads a 16-entry GPU configuration register file, starts renders, performs soft resets, and drives `gpuBusy` back to the buffer so that only reads are issued while the GPU is rendering. It is the receiving end of the `gpuCommand`/`gpuData`/`gpuBusy` interface and sits between the command buffer and the render pipeline.

## Interface
- `REG_COUNT`, 16, number of configuration registers (power of two, ≤ 16; address uses payload bits [3:0]).
- `WATCHDOG_CYCLES`, 16'hFFFF, render timeout in cycles (used only with the watchdog macro).
- `pipelineClock` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low.
- `gpuCommand` in 16: [15:14] opcode, [13:0] payload; sampled every cycle.
- `gpuData` in 16: write data for write opcode.
- `renderDone` in 1: single-cycle pulse from render pipeline.
- `gpuBusy` out 1: registered; 1 while in RENDER or SOFT_RESET.
- `renderStart` out 1: single-cycle pulse.
- `renderAbort` out 1: single-cycle pulse on watchdog expiry.
- `readRespValid` out 1: single-cycle pulse.
- `readRespData` out 16: register contents, valid with `readRespValid`.
- `protocolError` out 1: sticky error flag.

## Operation
- Opcodes: 00 NOP, 01 READ, 10 WRITE, 11 SPECIAL. Zero command = NOP (empty buffer emits zeros).
- READ/WRITE: payload[3:0] = address; payload[13:4] ≠ 0 or address ≥ REG_COUNT → command dropped, `protocolError` set.
- SPECIAL sub-op payload[13:12]: 00 RENDER_START, 01 SOFT_RESET, 10 CLEAR_ERROR, 11 reserved (drop, set error).
- States: IDLE, RENDER, SOFT_RESET.
- IDLE: all opcodes execute. RENDER_START → RENDER, `renderStart` pulse. SOFT_RESET → SOFT_RESET, index counter = 0.
- RENDER: READ executes; WRITE and SPECIAL (including CLEAR_ERROR) dropped, `protocolError` set. `renderDone` → IDLE.
- SOFT_RESET: clears register index `i` per cycle, i = 0..REG_COUNT-1, then → IDLE (REG_COUNT cycles). READ returns current contents (cleared or not); WRITE/SPECIAL dropped with error.
- `protocolError` cleared only by CLEAR_ERROR in IDLE; if set and cleared in same cycle, set wins.
- `renderDone` outside RENDER ignored, no error.

## Timing
- Reset values: `gpuBusy`, `renderStart`, `renderAbort`, `readRespValid`, `protocolError` = 0; `readRespData` = 0; all registers 0; state IDLE; counters 0.
- Command sampled at cycle N; effects registered at edge N+1: `readRespValid`/`readRespData`, register write, `renderStart`, `gpuBusy` rise.
- READ after WRITE to same address in next cycle returns new data; same-cycle read-during-write impossible (one command per cycle).
- `gpuBusy` falls at the edge after `renderDone` sampled, or after last SOFT_RESET clear cycle.
- `renderDone` and a command in same cycle: command evaluated against RENDER rules.
- Reset mid-RENDER or mid-SOFT_RESET: immediate return to IDLE, all outputs to reset values, no pulses.

## Configuration
- `GPU_CMD_WATCHDOG_EN` defined: 16-bit counter clears on RENDER entry, increments each RENDER cycle; reaching WATCHDOG_CYCLES → `renderAbort` pulse, `protocolError` set, → IDLE. `renderDone` in the expiry cycle wins: no abort, no error.
- Undefined: no counter, `renderAbort` tied 0, RENDER exits only on `renderDone`.

## Structure
- Package `gpu_cmd_pkg`: opcode constants, SPECIAL sub-op constants, state encoding, payload field positions.
- Sub-module `gpu_cmd_regfile`: REG_COUNT×16 registers, one write port, one registered read port, async clear on `reset`.

## Test plan
- WRITE 0x8003/data 0xBEEF, then READ 0x4003 → `readRespData` 0xBEEF, `readRespValid` 1 cycle, 1 cycle after READ.
- SPECIAL 0xC000 → `renderStart` pulse, `gpuBusy` 1; WRITE 0x8001 in RENDER → dropped, `protocolError` 1; READ 0x4001 serviced; `renderDone` → `gpuBusy` 0 next edge.
- Write regs 0..15, SPECIAL 0xD000 → `gpuBusy` 16 cycles, all reads afterwards return 0.
- READ 0x4010 → no response, `protocolError` 1; SPECIAL 0xE000 in IDLE → `protocolError` 0.
- With `GPU_CMD_WATCHDOG_EN`, WATCHDOG_CYCLES = 8, no `renderDone` → `renderAbort` after 8 RENDER cycles, `gpuBusy` 0; repeat with `renderDone` on cycle 8 → no abort.
- Assert `reset` low mid-RENDER → all outputs 0 asynchronously, registers 0, IDLE on release.

Source files
------------

// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: opcodes, SPECIAL sub-ops, decoder states and gpuCommand field positions.
package gpu_cmd_pkg;
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_SPECIAL = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        SUB_RENDER_START = 2'b00,
        SUB_SOFT_RESET   = 2'b01,
        SUB_CLEAR_ERROR  = 2'b10,
        SUB_RESERVED     = 2'b11
    } subop_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_RENDER     = 2'b01,
        ST_SOFT_RESET = 2'b10
    } state_t;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 14;
    localparam int SUB_MSB  = 13;
    localparam int SUB_LSB  = 12;
    localparam int PAD_MSB  = 13;
    localparam int PAD_LSB  = 4;
    localparam int ADDR_MSB = 3;
    localparam int ADDR_LSB = 0;
endpackage

// File: rtl/gpu_cmd_regfile.sv
// gpu_cmd_regfile: REG_COUNT x 16 configuration registers, one write port, registered read port.
module gpu_cmd_regfile #(
    parameter int REG_COUNT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata,
    input  logic        re,
    input  logic [3:0]  raddr,
    output logic [15:0] rdata
);
    logic [15:0] mem [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
endmodule

// File: rtl/gpu_command_decoder.sv
// gpu_command_decoder: executes the gpuCommand/gpuData stream against the config registers.
// Optional render watchdog enabled by defining GPU_CMD_WATCHDOG_EN.
module gpu_command_decoder
    import gpu_cmd_pkg::*;
#(
    parameter int          REG_COUNT       = 16,
    parameter logic [15:0] WATCHDOG_CYCLES = 16'hFFFF
) (
    input  logic        pipelineClock,
    input  logic        reset,
    input  logic [15:0] gpuCommand,
    input  logic [15:0] gpuData,
    input  logic        renderDone,
    output logic        gpuBusy,
    output logic        renderStart,
    output logic        renderAbort,
    output logic        readRespValid,
    output logic [15:0] readRespData,
    output logic        protocolError
);
    localparam logic [3:0] LAST_IDX = 4'(REG_COUNT - 1);

    state_t     state;
    opcode_t    op;
    subop_t     sub;
    logic [3:0] addr;
    logic [3:0] clr_idx;
    logic       addr_ok;
    logic       rd;
    logic       we;
    logic       err_set;
    logic       err_clr;
    logic       wd_expire;

    assign op      = opcode_t'(gpuCommand[OPC_MSB:OPC_LSB]);
    assign sub     = subop_t'(gpuCommand[SUB_MSB:SUB_LSB]);
    assign addr    = gpuCommand[ADDR_MSB:ADDR_LSB];
    assign addr_ok = gpuCommand[PAD_MSB:PAD_LSB] == '0 && {1'b0, addr} < 5'(REG_COUNT);
    assign rd      = op == OP_READ && addr_ok;
    // Soft reset borrows the write port to zero one register per cycle.
    assign we      = state == ST_SOFT_RESET || (state == ST_IDLE && op == OP_WRITE && addr_ok);
    assign err_clr = state == ST_IDLE && op == OP_SPECIAL && sub == SUB_CLEAR_ERROR;
    assign err_set = ((op == OP_READ || op == OP_WRITE) && !addr_ok)
                   || (state != ST_IDLE && (op == OP_WRITE || op == OP_SPECIAL))
                   || (state == ST_IDLE && op == OP_SPECIAL && sub == SUB_RESERVED)
                   || wd_expire;

    gpu_cmd_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
        .clk   (pipelineClock),
        .rst_n (reset),
        .we    (we),
        .waddr (state == ST_SOFT_RESET ? clr_idx : addr),
        .wdata (state == ST_SOFT_RESET ? 16'h0000 : gpuData),
        .re    (rd),
        .raddr (addr),
        .rdata (readRespData)
    );

    always_ff @(posedge pipelineClock or negedge reset)
        if (!reset) begin
            state         <= ST_IDLE;
            gpuBusy       <= 1'b0;
            renderStart   <= 1'b0;
            readRespValid <= 1'b0;
            protocolError <= 1'b0;
            clr_idx       <= '0;
        end else begin
            renderStart   <= 1'b0;
            readRespValid <= rd;
            protocolError <= err_set | (protocolError & ~err_clr);
            case (state)
                ST_IDLE:
                    if (op == OP_SPECIAL && sub == SUB_RENDER_START) begin
                        state       <= ST_RENDER;
                        gpuBusy     <= 1'b1;
                        renderStart <= 1'b1;
                    end else if (op == OP_SPECIAL && sub == SUB_SOFT_RESET) begin
                        state   <= ST_SOFT_RESET;
                        gpuBusy <= 1'b1;
                        clr_idx <= '0;
                    end
                ST_RENDER:
                    if (renderDone || wd_expire) begin
                        state   <= ST_IDLE;
                        gpuBusy <= 1'b0;
                    end
                ST_SOFT_RESET: begin
                    clr_idx <= clr_idx + 4'd1;
                    if (clr_idx == LAST_IDX) begin
                        state   <= ST_IDLE;
                        gpuBusy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gpuBusy <= 1'b0;
                end
            endcase
        end

`ifdef GPU_CMD_WATCHDOG_EN
    logic [15:0] wd_cnt;

    // renderDone in the expiry cycle takes precedence over the abort.
    assign wd_expire = state == ST_RENDER && !renderDone && wd_cnt == WATCHDOG_CYCLES - 16'd1;

    always_ff @(posedge pipelineClock or negedge reset)
        if (!reset) begin
            wd_cnt      <= '0;
            renderAbort <= 1'b0;
        end else begin
            wd_cnt      <= state == ST_RENDER ? wd_cnt + 16'd1 : '0;
            renderAbort <= wd_expire;
        end
`else
    assign wd_expire   = 1'b0;
    assign renderAbort = 1'b0;
`endif
endmodule
